// File: rtl/maze_pkg.sv
// Shared definitions for the maze solver's move path: direction codes,
// array sizes, and the path recorder's state encoding. The move queue
// imports this same package so both sides agree on widths and codes.
package maze_pkg;

    // Direction code recorded for each solver move.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    // Width of the exported path array; matches the move queue's array.
    localparam int MAZE_CELLS  = 256;
    // Largest move count the queue accepts (it rejects back == 8'hFE).
    localparam int STACK_DEPTH = 254;

    // Recorder phases: recording moves, one-cycle handoff, frozen.
    typedef enum logic [1:0] {
        RECORD  = 2'd0,
        HANDOFF = 2'd1,
        LOCKED  = 2'd2
    } rec_state_t;

endpackage

// File: rtl/path_recorder.sv
// path_recorder: writer side of the maze solver's move queue.
// It records 2-bit direction codes as a LIFO while the DFS explores. On finish
// it presents the whole path array and the last-index pointer, pulses
// load_queue for one cycle, and then freezes until init or reset.
//
// Ports:
//   clock, reset        rising-edge clock; asynchronous active-high reset
//   init                synchronous clear, same effect as reset, top priority
//   push, pop, dir_in   append dir_in / drop the last move (both = replace top)
//   finish              path complete; start the handoff
//   path_out            recorded moves, index 0 first; unused entries 2'b00
//   back                index of the last valid move, 8'hFF when empty
//   load_queue          one-cycle strobe; path_out and back are stable
//   top_dir             most recent move, DIR_UP when empty
//   full, empty         count == DEPTH / count == 0
//   overflow, underflow sticky push-while-full / pop-while-empty flags
//   locked              the handoff is done and the recorder is frozen
module path_recorder
    import maze_pkg::dir_t;
    import maze_pkg::DIR_UP;
    import maze_pkg::rec_state_t;
    import maze_pkg::RECORD;
    import maze_pkg::HANDOFF;
    import maze_pkg::LOCKED;
#(
    parameter int MAZE_CELLS = maze_pkg::MAZE_CELLS,
    parameter int DEPTH      = maze_pkg::STACK_DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       init,
    input  logic       push,
    input  logic       pop,
    input  dir_t       dir_in,
    input  logic       finish,
    output logic [1:0] path_out [0:MAZE_CELLS-1],
    output logic [7:0] back,
    output logic       load_queue,
    output dir_t       top_dir,
    output logic       full,
    output logic       empty,
    output logic       overflow,
    output logic       underflow,
    output logic       locked
);

    rec_state_t state_q, state_d;
    logic [8:0] count_q, count_d;
    logic       load_q, load_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic [1:0] path_q [0:MAZE_CELLS-1];

    // One array write per cycle at most: a push, a top replace, or a pop
    // clearing the vacated slot back to 2'b00.
    logic       wr_en;
    logic [7:0] wr_idx;
    logic [1:0] wr_val;

    logic [7:0] top_idx;

    assign top_idx = 8'(count_q - 9'd1);
    assign back    = top_idx;
    assign empty   = (count_q == 9'd0);
    assign full    = (count_q == 9'(DEPTH));
    assign top_dir = empty ? DIR_UP : dir_t'(path_q[top_idx]);

    assign load_queue = load_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;
    assign locked     = (state_q == LOCKED);
    assign path_out   = path_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = count_q[7:0];
        wr_val  = 2'b00;

        case (state_q)
            RECORD: begin
                if (finish) begin
                    // finish wins; any push/pop this cycle is dropped.
                    state_d = HANDOFF;
                end else if (push && pop && !empty) begin
                    wr_en  = 1'b1;
                    wr_idx = top_idx;
                    wr_val = dir_in;
                end else if (push) begin
                    // Also covers push+pop on an empty stack.
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = count_q[7:0];
                        wr_val  = dir_in;
                        count_d = count_q + 9'd1;
                    end
                end else if (pop) begin
                    if (empty) begin
                        unf_d = 1'b1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = top_idx;
                        wr_val  = 2'b00;
                        count_d = count_q - 9'd1;
                    end
                end
            end
            HANDOFF: state_d = LOCKED;
            LOCKED:  state_d = LOCKED;
            default: state_d = RECORD;
        endcase

        // The strobe is registered: high exactly while in HANDOFF.
        load_d = (state_d == HANDOFF);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RECORD;
            count_q <= 9'd0;
            load_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < MAZE_CELLS; i++) path_q[i] <= 2'b00;
        end else if (init) begin
            state_q <= RECORD;
            count_q <= 9'd0;
            load_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < MAZE_CELLS; i++) path_q[i] <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (wr_en) path_q[wr_idx] <= wr_val;
        end
    end

endmodule

// File: tb/tb_path_recorder.sv
module tb_path_recorder;
    import maze_pkg::*;

    localparam int CELLS = 256;
    localparam int DEP   = 254;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0, push = 1'b0, pop = 1'b0, finish = 1'b0;
    dir_t       dir_in = DIR_UP;
    logic [1:0] path_out [0:CELLS-1];
    logic [7:0] back;
    logic       load_queue, full, empty, overflow, underflow, locked;
    dir_t       top_dir;

    path_recorder #(.MAZE_CELLS(CELLS), .DEPTH(DEP)) dut (
        .clock(clock), .reset(reset), .init(init), .push(push), .pop(pop),
        .dir_in(dir_in), .finish(finish), .path_out(path_out), .back(back),
        .load_queue(load_queue), .top_dir(top_dir), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow), .locked(locked)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue as the stack plus flags and a phase.
    int m_stk[$];
    bit m_ovf, m_unf;
    int m_phase;   // 0 recording, 1 handing off, 2 frozen

    task automatic model_clear();
        m_stk.delete();
        m_ovf = 0; m_unf = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit p, input bit q, input int d, input bit f, input bit i);
        if (i) begin
            model_clear();
        end else if (m_phase == 0) begin
            if (f) m_phase = 1;
            else if (p && q && m_stk.size() > 0) m_stk[m_stk.size()-1] = d;
            else if (p) begin
                if (m_stk.size() == DEP) m_ovf = 1;
                else m_stk.push_back(d);
            end else if (q) begin
                if (m_stk.size() == 0) m_unf = 1;
                else void'(m_stk.pop_back());
            end
        end else begin
            m_phase = 2;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n, bad, first;
        n = m_stk.size();
        chk({tag, " back"}, int'(back), (n - 1) & 8'hFF);
        chk({tag, " empty"}, int'(empty), int'(n == 0));
        chk({tag, " full"}, int'(full), int'(n == DEP));
        chk({tag, " top_dir"}, int'(top_dir), (n > 0) ? m_stk[n-1] : 0);
        chk({tag, " load_queue"}, int'(load_queue), int'(m_phase == 1));
        chk({tag, " locked"}, int'(locked), int'(m_phase == 2));
        chk({tag, " overflow"}, int'(overflow), int'(m_ovf));
        chk({tag, " underflow"}, int'(underflow), int'(m_unf));
        bad = 0; first = -1;
        for (int k = 0; k < CELLS; k++) begin
            int e;
            e = (k < n) ? m_stk[k] : 0;
            if (path_out[k] !== 2'(e)) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        chk({tag, " path_out bad entries (first idx ", $sformatf("%0d", first), ")"}, bad, 0);
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input bit p, input bit q, input int d, input bit f, input bit i);
        push = p; pop = q; dir_in = dir_t'(d); finish = f; init = i;
        @(posedge clock);
        #1;
        model_step(p, q, d, f, i);
        push = 0; pop = 0; finish = 0; init = 0;
    endtask

    typedef struct {
        bit p, q, f, i;
        int d;
        int eback;
        bit eempty;
        int etop;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit p, bit q, int d, bit f, bit i, int eb, bit ee, int et);
        vec_t v;
        v.p = p; v.q = q; v.d = d; v.f = f; v.i = i;
        v.eback = eb; v.eempty = ee; v.etop = et;
        return v;
    endfunction

    initial begin
        // Reset state, checked while reset is still held.
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        check_all("reset");
        #3 reset = 0;
        @(posedge clock); #1;
        check_all("idle after reset");

        // Directed table: push 1,2,3; init; push 0,1,2; pop; push 3 + pop.
        vecs.push_back(mk(1,0,1,0,0, 8'h00, 0, 1));
        vecs.push_back(mk(1,0,2,0,0, 8'h01, 0, 2));
        vecs.push_back(mk(1,0,3,0,0, 8'h02, 0, 3));
        vecs.push_back(mk(0,0,0,0,1, 8'hFF, 1, 0));
        vecs.push_back(mk(1,0,0,0,0, 8'h00, 0, 0));
        vecs.push_back(mk(1,0,1,0,0, 8'h01, 0, 1));
        vecs.push_back(mk(1,0,2,0,0, 8'h02, 0, 2));
        vecs.push_back(mk(0,1,0,0,0, 8'h01, 0, 1));
        vecs.push_back(mk(1,1,3,0,0, 8'h01, 0, 3));
        vecs.push_back(mk(0,1,0,0,0, 8'h00, 0, 0));
        vecs.push_back(mk(0,1,0,0,0, 8'hFF, 1, 0));
        vecs.push_back(mk(1,1,2,0,0, 8'h00, 0, 2));
        for (int v = 0; v < vecs.size(); v++) begin
            step(vecs[v].p, vecs[v].q, vecs[v].d, vecs[v].f, vecs[v].i);
            chk($sformatf("vec%0d back", v), int'(back), vecs[v].eback);
            chk($sformatf("vec%0d empty", v), int'(empty), int'(vecs[v].eempty));
            chk($sformatf("vec%0d top_dir", v), int'(top_dir), vecs[v].etop);
            check_all($sformatf("vec%0d", v));
        end

        // Underflow, fill to DEPTH, overflow.
        step(0,0,0,0,1);
        step(0,1,0,0,0);
        chk("underflow sticky", int'(underflow), 1);
        chk("underflow back", int'(back), 8'hFF);
        chk("underflow empty", int'(empty), 1);
        for (int k = 0; k < DEP; k++) begin
            step(1,0,k % 4,0,0);
            if (k % 50 == 0) check_all("fill");
        end
        chk("full flag", int'(full), 1);
        chk("full back", int'(back), 8'hFD);
        step(1,0,3,0,0);
        chk("overflow flag", int'(overflow), 1);
        chk("overflow back", int'(back), 8'hFD);
        chk("underflow still set", int'(underflow), 1);
        check_all("overflow");

        // Finish with a push in the same cycle.
        step(0,0,0,0,1);
        step(1,0,2,0,0);
        step(1,0,1,0,0);
        chk("pre-finish load", int'(load_queue), 0);
        step(1,0,3,1,0);
        chk("handoff load", int'(load_queue), 1);
        chk("handoff back", int'(back), 8'h01);
        chk("handoff path0", int'(path_out[0]), 2);
        chk("handoff path1", int'(path_out[1]), 1);
        chk("handoff path2", int'(path_out[2]), 0);
        check_all("handoff");
        step(1,0,0,0,0);
        chk("after handoff load", int'(load_queue), 0);
        chk("after handoff locked", int'(locked), 1);
        chk("locked back", int'(back), 8'h01);
        step(1,0,0,1,0);
        step(0,1,0,0,0);
        chk("locked ignores load", int'(load_queue), 0);
        check_all("locked");

        // init from LOCKED, then recording resumes.
        step(0,0,0,0,1);
        chk("init locked", int'(locked), 0);
        chk("init back", int'(back), 8'hFF);
        check_all("init from locked");
        step(1,0,3,0,0);
        chk("resume back", int'(back), 8'h00);
        chk("resume top", int'(top_dir), 3);

        // Finish while empty still hands off with back = FF.
        step(0,0,0,0,1);
        step(0,0,0,1,0);
        chk("empty handoff load", int'(load_queue), 1);
        chk("empty handoff back", int'(back), 8'hFF);
        step(0,0,0,0,0);
        check_all("empty handoff done");

        // Asynchronous reset while load_queue is high.
        step(0,0,0,0,1);
        step(1,0,1,0,0);
        step(0,0,0,1,0);
        chk("pre-reset load", int'(load_queue), 1);
        reset = 1;
        #2;
        model_clear();
        chk("async reset load", int'(load_queue), 0);
        chk("async reset back", int'(back), 8'hFF);
        check_all("async reset");
        #1 reset = 0;
        @(posedge clock); #1;
        check_all("after async reset");

        // Randomized traffic against the model with a drifting push bias.
        for (int c = 0; c < 4000; c++) begin
            int bias, r;
            bit p, q, f, i;
            bias = ((c / 500) % 2 == 0) ? 85 : 45;
            r = $urandom_range(99);
            p = (r < bias);
            q = ($urandom_range(99) < 40);
            f = ($urandom_range(399) == 0);
            i = ($urandom_range(249) == 0);
            step(p, q, $urandom_range(3), f, i);
            check_all("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/path_recorder.md
Name: path_recorder

Overview:
- Writer side of the maze solver's move queue. Records the solver's 2-bit direction codes as a LIFO during DFS exploration.
- Push adds a move when the solver advances. Pop removes the last move when it backtracks.
- On finish, presents the full path array and last-index pointer to the move queue and pulses a one-cycle load strobe.
- Sits between the DFS controller and the move queue; the queue then replays the moves in forward order.

Parameters:
- MAZE_CELLS, 256, width of the exported path array; matches the queue's array size.
- DEPTH, 254, maximum stored moves. The queue rejects a load when back == 8'hFE, so DEPTH must not exceed 254.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  synchronous clear; same effect as reset, sampled on the clock edge.
- push  input  1  append dir_in to the path.
- pop  input  1  remove the most recent move (backtrack).
- dir_in  input  2  direction code to record (dir_t).
- finish  input  1  path complete; start handoff to the queue.
- path_out  output  2 x [0:MAZE_CELLS-1]  recorded moves; index 0 is the first move.
- back  output  8  index of the last valid move; 8'hFF when empty.
- load_queue  output  1  one-cycle strobe; path_out and back are valid and stable.
- top_dir  output  2  most recent move; 2'b00 when empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky; a push was attempted while full.
- underflow  output  1  sticky; a pop was attempted while empty.
- locked  output  1  a handoff is done and the recorder is frozen.

Behaviour:
- Reset/init values:
  - count = 0, back = 8'hFF, every path_out entry = 2'b00 (never z).
  - load_queue = 0, overflow = 0, underflow = 0, locked = 0.
  - State goes to RECORD.
  - init has priority over all other inputs in the same cycle.
- count is 9 bits, internal. back = count - 1, truncated to 8 bits, so count 0 gives 8'hFF.
- State machine:
  - RECORD: accepts push and pop.
    - push only, not full: path[count] <= dir_in, count += 1.
    - pop only, not empty: path[count-1] <= 2'b00, count -= 1.
    - push and pop together, not empty: the top entry is overwritten with dir_in; count unchanged.
    - push and pop together, empty: treated as a push.
    - push while full: ignored, overflow <= 1.
    - pop while empty: ignored, underflow <= 1.
    - finish: go to HANDOFF. push and pop in the same cycle are ignored. finish has priority.
  - HANDOFF: lasts one cycle. load_queue = 1 (registered, asserted the cycle after finish is sampled). Go to LOCKED.
  - LOCKED: load_queue = 0, locked = 1. Ignores push, pop and finish. path_out and back hold until init or reset.
- finish while empty: HANDOFF still occurs with back = 8'hFF, so the queue loads empty.
- Updates are visible one cycle after the edge: top_dir, full, empty and back are combinational from the registered count and array.
- Reset asserted mid-handoff: load_queue drops immediately (asynchronous) and all state clears.

Decomposition:
- Package maze_pkg holds:
  - typedef dir_t as a 2-bit enum: DIR_UP=0, DIR_RIGHT=1, DIR_DOWN=2, DIR_LEFT=3.
  - MAZE_CELLS=256 and STACK_DEPTH=254.
  - The state enum {RECORD, HANDOFF, LOCKED}.
- The move queue imports the same package.
- Single module; no sub-module is natural, since the storage is tightly coupled to the export array.

Test Plan:
- Reset, then push 1,2,3 -> back=8'h02, path_out[0..2]=1,2,3, top_dir=3, empty=0, all other entries 2'b00.
- Push 0,1,2, then pop, then push 3 with pop in the same cycle -> back=8'h01, path_out[0..1]=0,3, path_out[2]=2'b00.
- Pop when empty -> back stays 8'hFF, underflow=1 (sticky), empty=1. Then 254 pushes -> full=1, back=8'hFD. A 255th push -> back unchanged, overflow=1.
- Push 2,1, then finish (with push asserted in the same cycle):
  - push ignored; load_queue high for exactly one cycle, one clock after finish;
  - back=8'h01; locked=1 afterwards; further pushes ignored.
- From LOCKED, init -> all entries 2'b00, back=8'hFF, locked=0, flags cleared. Recording resumes.
- Reset asserted asynchronously while load_queue=1 -> load_queue=0 before the next clock edge, back=8'hFF.
